ps2_scan_ctrl: RTL and testbench
================================

// Module: ps2_scan_ctrl
// PURPOSE
//  Sequencer between ps2_keyboard (byte FIFO, active-low pop) and key consumers.
//  Pops scancode bytes, folds E0/F0 prefixes into one key event, suppresses typematic repeats,
//  and presents events on a valid/ready port. Counts key presses and flags device errors.
// PARAMETERS
//  REPEAT_EN  0  1 = pass typematic repeat makes through; 0 = suppress them
//  CNT_W      8  width of press counter
// PORTS
//  clk         in   1      system clock; all state on posedge
//  clrn        in   1      asynchronous active-low reset
//  kb_ready    in   1      ps2_keyboard FIFO non-empty
//  kb_data     in   8      FIFO head byte, valid while kb_ready=1
//  kb_overflow in   1      ps2_keyboard FIFO overflow
//  kb_nextdata_n out 1     pop strobe to ps2_keyboard, active low, one cycle
//  ev_valid    out  1      key event available
//  ev_ready    in   1      consumer accepts event (transfer = ev_valid & ev_ready)
//  ev_code     out  8      scancode (prefixes stripped)
//  ev_ext      out  1      event carried E0 prefix
//  ev_brk      out  1      1 = release (F0), 0 = press
//  press_cnt   out  CNT_W  count of emitted press events, wraps
//  err         out  1      sticky: 00/FF byte or kb_overflow seen; cleared only by reset
// BEHAVIOUR
//  Reset (clrn=0, async): state IDLE; kb_nextdata_n=1; ev_valid=0; ev_code=0; ev_ext=0;
//   ev_brk=0; press_cnt=0; err=0; ext/brk prefix flags=0; held_vld=0.
//  FSM: IDLE -> POP -> SETTLE -> IDLE.
//   IDLE: take byte when kb_ready & (~ev_valid | ev_ready); decode kb_data this cycle; go POP.
//   POP: kb_nextdata_n=0 for exactly this cycle; go SETTLE.
//   SETTLE: one dead cycle so kb_ready/kb_data reflect new FIFO head; go IDLE.
//   Max throughput: one byte per 3 cycles. kb_nextdata_n is 1 in every state but POP.
//  Decode (in IDLE on take):
//   E0 -> ext_f=1, no event.  F0 -> brk_f=1, no event.
//   00 or FF -> err=1, clear ext_f/brk_f, no event.
//   other -> candidate event {ext_f, brk_f, byte}; clear ext_f/brk_f.
//  Repeat filter (REPEAT_EN=0): make whose {ext,code} equals held key while held_vld=1 is
//   dropped. Emitted make: held={ext,code}, held_vld=1. Break matching held: held_vld=0.
//   Break of non-held key: emitted, held unchanged.
//  Output: emitted event loads ev_* and sets ev_valid next cycle. ev_* stable while
//   ev_valid & ~ev_ready. Transfer clears ev_valid unless a new event loads the same cycle
//   (new load wins, ev_valid stays 1). No event ever dropped for backpressure: FSM stalls in IDLE.
//  press_cnt += 1 (mod 2^CNT_W) per emitted make, at load time.
//  kb_overflow=1 in any cycle -> err=1. Bytes still processed normally.
//  Reset mid-sequence: prefix flags lost; a pending POP is not issued.
// STRUCTURE
//  ps2_pkg: localparams SC_EXT=8'hE0, SC_BRK=8'hF0, SC_ERR0=8'h00, SC_ERR1=8'hFF;
//   state encodings S_IDLE/S_POP/S_SETTLE (2 bit).
//  Single module; no sub-module. ps2_keyboard instanced alongside in top, clrn shared.
// TESTING
//  Bench models ps2_keyboard FIFO (ready/data, pop on nextdata_n low).
//  1 FIFO 1C,F0,1C, ev_ready=1 -> events {0,0,1C},{0,1,1C}; press_cnt=1; 3 pops, each 1 cycle low.
//  2 FIFO E0,75,E0,F0,75 -> {1,0,75},{1,1,75}; no event for prefixes; 5 pops.
//  3 FIFO 1C,1C,1C,F0,1C, REPEAT_EN=0 -> exactly 2 events, press_cnt=1; REPEAT_EN=1 -> 4 events, press_cnt=3.
//  4 ev_ready=0, FIFO 1C,32 -> ev_valid=1 code 1C held stable, kb_nextdata_n stays 1 after
//    first pop; raise ev_ready -> 32 follows, no loss.
//  5 FIFO FF then 1C; separately pulse kb_overflow -> err=1 sticky, 1C still emitted.
//  6 clrn low between F0 and 1C, then FIFO 1C -> event {0,0,1C} (break flag lost); outputs at reset values.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - scancode constants and sequencer state encoding for the PS/2 scan controller
package ps2_pkg;

    localparam logic [7:0] SC_EXT  = 8'hE0;
    localparam logic [7:0] SC_BRK  = 8'hF0;
    localparam logic [7:0] SC_ERR0 = 8'h00;
    localparam logic [7:0] SC_ERR1 = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_POP    = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

endpackage

// File: rtl/ps2_scan_ctrl.sv
// rtl/ps2_scan_ctrl.sv - pops PS/2 scancode bytes, folds prefixes into key events, filters typematic repeats
module ps2_scan_ctrl
    import ps2_pkg::*;
#(
    parameter int REPEAT_EN = 0,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             kb_ready,
    input  logic [7:0]       kb_data,
    input  logic             kb_overflow,
    output logic             kb_nextdata_n,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [7:0]       ev_code,
    output logic             ev_ext,
    output logic             ev_brk,
    output logic [CNT_W-1:0] press_cnt,
    output logic             err
);

    localparam bit FILTER_ON = (REPEAT_EN == 0);

    state_t           r_state;
    state_t           w_state_nx;
    logic             r_nextdata_n;
    logic             r_ev_valid;
    logic [7:0]       r_ev_code;
    logic             r_ev_ext;
    logic             r_ev_brk;
    logic [CNT_W-1:0] r_press_cnt;
    logic             r_err;
    logic             r_ext_f;
    logic             r_brk_f;
    logic [8:0]       r_held_key;
    logic             r_held_vld;

    logic w_take;
    logic w_is_ext;
    logic w_is_brk;
    logic w_is_err;
    logic w_cand;
    logic w_held_hit;
    logic w_drop;
    logic w_emit;

    // A byte is only taken when the output slot is free or being drained this cycle.
    assign w_take     = (r_state == S_IDLE) & kb_ready & (~r_ev_valid | ev_ready);
    assign w_is_ext   = (kb_data == SC_EXT);
    assign w_is_brk   = (kb_data == SC_BRK);
    assign w_is_err   = (kb_data == SC_ERR0) | (kb_data == SC_ERR1);
    assign w_cand     = w_take & ~w_is_ext & ~w_is_brk & ~w_is_err;
    assign w_held_hit = r_held_vld & (r_held_key == {r_ext_f, kb_data});
    assign w_drop     = FILTER_ON & ~r_brk_f & w_held_hit;
    assign w_emit     = w_cand & ~w_drop;

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:   if (w_take) w_state_nx = S_POP;
            S_POP:    w_state_nx = S_SETTLE;
            S_SETTLE: w_state_nx = S_IDLE;
            default:  w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state      <= S_IDLE;
            r_nextdata_n <= 1'b1;
            r_ev_valid   <= 1'b0;
            r_ev_code    <= 8'h00;
            r_ev_ext     <= 1'b0;
            r_ev_brk     <= 1'b0;
            r_press_cnt  <= '0;
            r_err        <= 1'b0;
            r_ext_f      <= 1'b0;
            r_brk_f      <= 1'b0;
            r_held_key   <= 9'h000;
            r_held_vld   <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_nextdata_n <= (w_state_nx != S_POP);

            if (kb_overflow || (w_take && w_is_err)) begin
                r_err <= 1'b1;
            end

            if (w_take) begin
                if (w_is_ext) begin
                    r_ext_f <= 1'b1;
                end else if (w_is_brk) begin
                    r_brk_f <= 1'b1;
                end else begin
                    r_ext_f <= 1'b0;
                    r_brk_f <= 1'b0;
                end
            end

            if (w_emit) begin
                if (!r_brk_f) begin
                    r_held_key <= {r_ext_f, kb_data};
                    r_held_vld <= 1'b1;
                end else if (w_held_hit) begin
                    r_held_vld <= 1'b0;
                end
            end

            // A fresh load takes priority over clearing valid on a transfer.
            if (w_emit) begin
                r_ev_valid <= 1'b1;
                r_ev_code  <= kb_data;
                r_ev_ext   <= r_ext_f;
                r_ev_brk   <= r_brk_f;
                if (!r_brk_f) begin
                    r_press_cnt <= r_press_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else if (r_ev_valid && ev_ready) begin
                r_ev_valid <= 1'b0;
            end
        end
    end

    assign kb_nextdata_n = r_nextdata_n;
    assign ev_valid      = r_ev_valid;
    assign ev_code       = r_ev_code;
    assign ev_ext        = r_ev_ext;
    assign ev_brk        = r_ev_brk;
    assign press_cnt     = r_press_cnt;
    assign err           = r_err;

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// tb/tb_ps2_scan_ctrl.sv - scoreboard bench for ps2_scan_ctrl with repeat filter on (dut0) and off (dut1)
module tb_ps2_scan_ctrl;

    logic            clk = 1'b0;
    logic            clrn = 1'b0;
    logic [1:0]      kb_ready = 2'b00;
    logic [1:0][7:0] kb_data = '0;
    logic            kb_overflow = 1'b0;
    logic [1:0]      kb_nd;
    logic [1:0]      ev_valid;
    logic            ev_ready = 1'b1;
    logic [1:0][7:0] ev_code;
    logic [1:0]      ev_ext;
    logic [1:0]      ev_brk;
    logic [1:0][7:0] press_cnt;
    logic [1:0]      err;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_dut
            ps2_scan_ctrl #(.REPEAT_EN(g), .CNT_W(8)) u_dut (
                .clk          (clk),
                .clrn         (clrn),
                .kb_ready     (kb_ready[g]),
                .kb_data      (kb_data[g]),
                .kb_overflow  (kb_overflow),
                .kb_nextdata_n(kb_nd[g]),
                .ev_valid     (ev_valid[g]),
                .ev_ready     (ev_ready),
                .ev_code      (ev_code[g]),
                .ev_ext       (ev_ext[g]),
                .ev_brk       (ev_brk[g]),
                .press_cnt    (press_cnt[g]),
                .err          (err[g])
            );
        end
    endgenerate

    int         checks = 0;
    int         errors = 0;
    logic [7:0] fifo[2][$];
    logic [9:0] expq[2][$];
    int         pops[2] = '{0, 0};
    int         base[2] = '{0, 0};
    logic       prev_nd[2] = '{1'b1, 1'b1};
    logic       stall[2] = '{1'b0, 1'b0};
    logic [9:0] snap[2];

    // Keyboard FIFO model: pop on a low strobe, head presented from the following negedge.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!kb_nd[i]) begin
                checks++;
                if (!prev_nd[i]) begin
                    errors++;
                    $display("FAIL pop_width dut%0d strobe low for 2+ cycles, required 1", i);
                end
                pops[i]++;
                if (fifo[i].size() != 0) fifo[i].delete(0);
            end
            prev_nd[i] = kb_nd[i];
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            kb_ready[i] = (fifo[i].size() != 0);
            kb_data[i]  = (fifo[i].size() != 0) ? fifo[i][0] : 8'h00;
        end
    end

    // Monitor: compares each transfer against the scoreboard and checks stability under backpressure.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [9:0] got;
            logic [9:0] e;
            got = {ev_ext[i], ev_brk[i], ev_code[i]};
            if (clrn && ev_valid[i] && ev_ready) begin
                checks++;
                if (expq[i].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event dut%0d got %h, required none", i, got);
                end else begin
                    e = expq[i].pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL event dut%0d got %h, required %h", i, got, e);
                    end
                end
            end
            if (clrn && ev_valid[i] && !ev_ready) begin
                if (stall[i]) begin
                    checks++;
                    if (got !== snap[i]) begin
                        errors++;
                        $display("FAIL stable dut%0d got %h, required %h", i, got, snap[i]);
                    end
                end
                stall[i] = 1'b1;
                snap[i]  = got;
            end else begin
                stall[i] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d got %0h, required %0h", name, i, act, req);
        end
    endtask

    task automatic push(input logic [7:0] b);
        for (int i = 0; i < 2; i++) fifo[i].push_back(b);
    endtask

    task automatic exp_ev(input logic [1:0] m, input logic ext, input logic brk, input logic [7:0] code);
        for (int i = 0; i < 2; i++) if (m[i]) expq[i].push_back({ext, brk, code});
    endtask

    task automatic do_reset;
        @(posedge clk);
        #1;
        clrn        = 1'b0;
        ev_ready    = 1'b1;
        kb_overflow = 1'b0;
        for (int i = 0; i < 2; i++) begin
            fifo[i].delete();
            expq[i].delete();
        end
        #2;
        for (int i = 0; i < 2; i++) begin
            check("rst_valid", i, 32'(ev_valid[i]), 0);
            check("rst_code", i, 32'(ev_code[i]), 0);
            check("rst_extbrk", i, 32'({ev_ext[i], ev_brk[i]}), 0);
            check("rst_cnt", i, 32'(press_cnt[i]), 0);
            check("rst_err", i, 32'(err[i]), 0);
            check("rst_nd", i, 32'(kb_nd[i]), 1);
        end
        @(posedge clk);
        #1;
        clrn = 1'b1;
        for (int i = 0; i < 2; i++) base[i] = pops[i];
    endtask

    task automatic drain(input int budget);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            done = (fifo[0].size() == 0) && (fifo[1].size() == 0) &&
                   (expq[0].size() == 0) && (expq[1].size() == 0) && (ev_valid == 2'b00);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got %0d cycles, required completion", n);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_pops(input int n);
        for (int i = 0; i < 2; i++) check("pops", i, pops[i] - base[i], n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout, required finish");
        $fatal(1);
    end

    initial begin
        // Make then break of 1C
        do_reset();
        push(8'h1C); push(8'hF0); push(8'h1C);
        exp_ev(2'b11, 0, 0, 8'h1C); exp_ev(2'b11, 0, 1, 8'h1C);
        drain(100);
        for (int i = 0; i < 2; i++) check("cnt_t1", i, 32'(press_cnt[i]), 1);
        check_pops(3);

        // Extended key make/break; prefixes produce no event
        do_reset();
        push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
        exp_ev(2'b11, 1, 0, 8'h75); exp_ev(2'b11, 1, 1, 8'h75);
        drain(100);
        for (int i = 0; i < 2; i++) check("cnt_t2", i, 32'(press_cnt[i]), 1);
        check_pops(5);

        // Typematic repeats: dropped by dut0, passed by dut1
        do_reset();
        push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
        exp_ev(2'b11, 0, 0, 8'h1C);
        exp_ev(2'b10, 0, 0, 8'h1C); exp_ev(2'b10, 0, 0, 8'h1C);
        exp_ev(2'b11, 0, 1, 8'h1C);
        drain(100);
        check("cnt_t3", 0, 32'(press_cnt[0]), 1);
        check("cnt_t3", 1, 32'(press_cnt[1]), 3);
        check_pops(5);

        // Backpressure: first event held, no further pops until accepted
        do_reset();
        ev_ready = 1'b0;
        push(8'h1C); push(8'h32);
        exp_ev(2'b11, 0, 0, 8'h1C); exp_ev(2'b11, 0, 0, 8'h32);
        repeat (15) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("bp_valid", i, 32'(ev_valid[i]), 1);
            check("bp_code", i, 32'(ev_code[i]), 32'h1C);
            check("bp_nd", i, 32'(kb_nd[i]), 1);
        end
        check_pops(1);
        ev_ready = 1'b1;
        drain(100);
        for (int i = 0; i < 2; i++) check("cnt_t4", i, 32'(press_cnt[i]), 2);
        check_pops(2);

        // Error byte, then overflow pulse; err sticky, events still flow
        do_reset();
        push(8'hFF); push(8'h1C);
        exp_ev(2'b11, 0, 0, 8'h1C);
        drain(100);
        for (int i = 0; i < 2; i++) check("err_ff", i, 32'(err[i]), 1);
        do_reset();
        kb_overflow = 1'b1;
        @(posedge clk);
        #1;
        kb_overflow = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) check("err_ovf", i, 32'(err[i]), 1);
        push(8'h1C);
        exp_ev(2'b11, 0, 0, 8'h1C);
        drain(100);
        for (int i = 0; i < 2; i++) check("err_sticky", i, 32'(err[i]), 1);

        // Reset between F0 and 1C drops the break prefix
        do_reset();
        push(8'h1C); push(8'hF0);
        exp_ev(2'b11, 0, 0, 8'h1C);
        drain(100);
        do_reset();
        push(8'h1C);
        exp_ev(2'b11, 0, 0, 8'h1C);
        drain(100);
        for (int i = 0; i < 2; i++) check("cnt_t6", i, 32'(press_cnt[i]), 1);
        check_pops(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
